// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer of the async FIFO, presenting words as a
// valid/ready stream through a 2-entry (head + skid) output buffer.
//
// Ports:
//   rclk, rrst_n        read-domain clock, synchronous active-low reset
//   rempty, rdata, rinc FIFO read port (empty flag, read data, pop request)
//   rq2_wptr, rptr      synchronized write pointer and local read pointer (Gray)
//   m_valid, m_data     output stream word
//   m_ready             downstream accept
//   rlevel              FIFO occupancy seen from the read domain
//                       (only when FIFO_RLEVEL_EN is defined)
//
// Optional feature macro: FIFO_RLEVEL_EN adds the rlevel port and its logic.
module fifo_rd_stream #(
   parameter int DSIZE = 8,
   parameter int ASIZE = 3
) (
   input  logic             rclk,
   input  logic             rrst_n,
   input  logic             rempty,
   input  logic [DSIZE-1:0] rdata,
   output logic             rinc,
   input  logic [ASIZE:0]   rq2_wptr,
   input  logic [ASIZE:0]   rptr,
   output logic             m_valid,
   output logic [DSIZE-1:0] m_data,
   input  logic             m_ready
`ifdef FIFO_RLEVEL_EN
   ,
   output logic [ASIZE:0]   rlevel
`endif
);

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

   state_t           state;
   logic [DSIZE-1:0] head;
   logic [DSIZE-1:0] skid;
   logic             push;
   logic             pop;

   // rinc depends only on registered state and rempty, so m_ready never
   // reaches the FIFO pointer logic combinationally.
   assign rinc    = rrst_n & ~rempty & (state != FULL);
   assign push    = rinc;
   assign pop     = m_valid & m_ready;
   assign m_valid = (state != EMPTY);
   assign m_data  = head;

   // Head always holds the oldest word; skid only fills while head is stalled.
   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         state <= EMPTY;
         head  <= '0;
         skid  <= '0;
      end else begin
         case (state)
            EMPTY: if (push) begin
               state <= ONE;
               head  <= rdata;
            end
            ONE: if (push && !pop) begin
               state <= FULL;
               skid  <= rdata;
            end else if (push) begin
               head  <= rdata;
            end else if (pop) begin
               state <= EMPTY;
            end
            FULL: if (pop) begin
               state <= ONE;
               head  <= skid;
            end
            default: state <= EMPTY;
         endcase
      end
   end

`ifdef FIFO_RLEVEL_EN
   localparam logic [ASIZE:0] LMAX = {1'b1, {ASIZE{1'b0}}};

   function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
      logic [ASIZE:0] b;
      b = g;
      for (int i = ASIZE - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   logic [ASIZE:0] diff;

   // Modular subtraction handles pointer wrap; clamp guards against a
   // transiently inconsistent synchronized pointer.
   assign diff = gray2bin(rq2_wptr) - gray2bin(rptr);

   always_ff @(posedge rclk) begin
      if (!rrst_n) rlevel <= '0;
      else         rlevel <= (diff > LMAX) ? LMAX : diff;
   end
`else
   logic unused_ptrs;
   assign unused_ptrs = ^{rq2_wptr, rptr};
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed self-checking bench for fifo_rd_stream with a
// queue-based model of the FIFO read port.
module tb_fifo_rd_stream;

   logic       rclk = 1'b0;
   logic       rrst_n;
   logic       rempty;
   logic [7:0] rdata;
   logic       rinc;
   logic [3:0] rq2_wptr;
   logic [3:0] rptr;
   logic       m_valid;
   logic [7:0] m_data;
   logic       m_ready;
`ifdef FIFO_RLEVEL_EN
   logic [3:0] rlevel;
`endif

   int         checks = 0;
   int         errors = 0;
   int         pulses = 0;
   int         viol   = 0;
   logic       hold_empty = 1'b0;
   logic [7:0] q[$];
   logic [7:0] sexp[3] = '{8'h11, 8'h22, 8'h33};

   fifo_rd_stream #(.DSIZE(8), .ASIZE(3)) dut (
      .rclk     (rclk),
      .rrst_n   (rrst_n),
      .rempty   (rempty),
      .rdata    (rdata),
      .rinc     (rinc),
      .rq2_wptr (rq2_wptr),
      .rptr     (rptr),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_ready  (m_ready)
`ifdef FIFO_RLEVEL_EN
      ,
      .rlevel   (rlevel)
`endif
   );

   always #5 rclk = ~rclk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic upd;
      rempty = hold_empty || (q.size() == 0);
      rdata  = (q.size() != 0) ? q[0] : 8'h00;
      #1;
   endtask

   task automatic cyc;
      logic pr;
      pr = rinc;
      if (pr && rempty) viol++;
      @(posedge rclk);
      #1;
      if (pr) begin
         pulses++;
         if (q.size() != 0) void'(q.pop_front());
      end
      if (!rrst_n) q.delete();
      upd();
   endtask

   initial begin
      rrst_n   = 1'b0;
      m_ready  = 1'b0;
      rq2_wptr = 4'b0000;
      rptr     = 4'b0000;
      q.push_back(8'hAA);
      upd();
      // reset holds off rinc even with data available
      chk("rst_rinc", rinc, 1'b0);
      q.push_back(8'hAA);
      cyc();
      cyc();
      chk("rst_valid", m_valid, 1'b0);
      chk("rst_data", m_data, 8'h00);
`ifdef FIFO_RLEVEL_EN
      chk("rst_level", rlevel, 4'd0);
`endif
      // first push on the first edge after release
      q.push_back(8'hAA);
      upd();
      rrst_n = 1'b1;
      #1;
      chk("rel_rinc", rinc, 1'b1);
      cyc();
      chk("first_word", {m_valid, m_data}, {1'b1, 8'hAA});
      m_ready = 1'b1;
      cyc();
      chk("first_drain", m_valid, 1'b0);

      // streaming at full rate
      pulses = 0;
      q.push_back(8'h11);
      q.push_back(8'h22);
      q.push_back(8'h33);
      upd();
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("stream", {m_valid, m_data}, {1'b1, sexp[i]});
      end
      cyc();
      chk("stream_end", m_valid, 1'b0);
      chk("stream_pulses", pulses, 3);

      // backpressure: only two words pulled, then ordered drain without gaps
      m_ready = 1'b0;
      pulses  = 0;
      for (int i = 1; i <= 5; i++) q.push_back(8'(i));
      upd();
      for (int i = 0; i < 4; i++) cyc();
      chk("bp_pulses", pulses, 2);
      chk("bp_rinc", rinc, 1'b0);
      chk("bp_hold", {m_valid, m_data}, {1'b1, 8'h01});
      m_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         cyc();
         chk("bp_drain", {m_valid, m_data}, {1'b1, 8'(i)});
      end
      cyc();
      chk("bp_end", m_valid, 1'b0);

      // empty boundary
      pulses     = 0;
      hold_empty = 1'b1;
      q.push_back(8'h5A);
      q.push_back(8'h6B);
      upd();
      for (int i = 0; i < 4; i++) cyc();
      chk("empty_pulses", pulses, 0);
      chk("empty_valid", m_valid, 1'b0);
      hold_empty = 1'b0;
      upd();
      cyc();
      hold_empty = 1'b1;
      upd();
      chk("one_word", {m_valid, m_data}, {1'b1, 8'h5A});
      for (int i = 0; i < 3; i++) cyc();
      chk("one_pulses", pulses, 1);
      chk("one_end", m_valid, 1'b0);
      q.delete();
      hold_empty = 1'b0;
      upd();

      // mid-stream reset from FULL
      m_ready = 1'b0;
      q.push_back(8'h71);
      q.push_back(8'h72);
      q.push_back(8'h73);
      upd();
      for (int i = 0; i < 3; i++) cyc();
      chk("full_head", {m_valid, m_data}, {1'b1, 8'h71});
      rrst_n = 1'b0;
      #1;
      cyc();
      chk("mid_rst", {m_valid, m_data}, {1'b0, 8'h00});
      rrst_n  = 1'b1;
      m_ready = 1'b1;
      q.push_back(8'h81);
      upd();
      cyc();
      chk("post_rst", {m_valid, m_data}, {1'b1, 8'h81});
      cyc();
      chk("post_end", m_valid, 1'b0);

`ifdef FIFO_RLEVEL_EN
      rq2_wptr = 4'b0011;
      rptr     = 4'b1001;
      cyc();
      chk("lvl_wrap", rlevel, 4'd4);
      rq2_wptr = 4'b1100;
      rptr     = 4'b0000;
      cyc();
      chk("lvl_full", rlevel, 4'd8);
      rq2_wptr = 4'b1111;
      cyc();
      chk("lvl_clamp", rlevel, 4'd8);
`endif

      chk("rempty_trust", viol, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side consumer for the asynchronous FIFO, in the rclk domain. It drives the FIFO read port (`rempty`, `rinc`, `rdata`) and presents the words as an AXI-style valid/ready stream. A 2-entry output buffer keeps full throughput, and `m_ready` has no combinational path to `rinc`. It also reports the FIFO occupancy as seen from the read domain, computed from the synchronized write pointer and the local read pointer.

## Interface
Parameters:
- DSIZE, 8, data word width
- ASIZE, 3, FIFO address width; pointers are ASIZE+1 bits, Gray coded

Ports:
- rclk  in  1  read-domain clock
- rrst_n  in  1  reset, synchronous, active-low
- rempty  in  1  registered FIFO empty flag
- rdata  in  DSIZE  memory read data at the current read address; valid in any cycle where rempty=0
- rinc  out  1  pop request to the FIFO pointer logic
- rq2_wptr  in  ASIZE+1  write pointer (Gray), already synchronized into rclk
- rptr  in  ASIZE+1  current read pointer (Gray)
- m_valid  out  1  output word available
- m_data  out  DSIZE  output word
- m_ready  in  1  downstream accepts m_data
- rlevel  out  ASIZE+1  FIFO occupancy; present only with FIFO_RLEVEL_EN

## Operation
- Buffer: 2 entries, head (H) and skid (S), plus a count register cnt in 0..2.
- States:
  - EMPTY: cnt=0
  - ONE: cnt=1, H valid
  - FULL: cnt=2, H and S valid; H is older
- pop = m_valid & m_ready.
- rinc = rrst_n & ~rempty & (cnt != 2). It is a function of registered state and `rempty` only.
- push = rinc. On push, rdata is captured at the same edge.
- Transitions:
  - EMPTY + push: → ONE, H=rdata.
  - ONE:
    - push & ~pop: → FULL, S=rdata.
    - push & pop: stays ONE, H=rdata.
    - pop & ~push: → EMPTY.
  - FULL:
    - pop: → ONE, H=S. No push is possible in FULL.
  - Otherwise: hold.
- m_valid = (cnt != 0). m_data = H, registered.
- Ordering is strict FIFO. No word is duplicated or dropped.
- rempty is trusted as-is: rinc is never asserted while rempty=1.
- Level computation (with FIFO_RLEVEL_EN):
  - wbin = gray2bin(rq2_wptr); rbin = gray2bin(rptr).
  - diff = (wbin − rbin) mod 2^(ASIZE+1).
  - rlevel <= min(diff, 2^ASIZE), registered.
  - The value is conservative: the write pointer lags by the synchronizer delay.

## Timing
- Reset: when rrst_n=0 at a rising rclk edge:
  - cnt=0, m_valid=0, m_data=0, rlevel=0.
  - rinc=0 combinationally while rrst_n=0.
- Reset mid-operation: buffered words are discarded, and m_valid is 0 after that edge. The FIFO pointer logic is reset by the same rrst_n.
- Latency: with rempty=0 and cnt<2 at edge t, the word is captured at t, and m_valid=1 with m_data=word during cycle t+1.
- Throughput: one word per cycle sustained when m_ready=1 and the FIFO is non-empty (steady state ONE with push & pop).
- Backpressure: with m_ready=0, at most 2 words are pulled after the last pop. Then rinc=0 until a pop.
- Handshake: m_data stays stable while m_valid=1 & m_ready=0.
- rlevel: registered, 1 cycle after the inputs. At wrap-around (pointer MSB toggling), the modular subtraction gives correct occupancy.

## Configuration
- FIFO_RLEVEL_EN defined:
  - rlevel port, gray-to-binary converters and the level register are present.
- Not defined:
  - rlevel port and logic are absent.
  - Stream behaviour is identical.

## Test plan
- Reset: hold rrst_n=0 with rempty=0 → rinc=0, m_valid=0, rlevel=0. After release, the first push occurs on the first edge with rempty=0.
- Streaming: FIFO holds 0x11,0x22,0x33 with m_ready=1 → m_data 0x11,0x22,0x33 on consecutive cycles, rinc high for 3 cycles, then m_valid=0.
- Backpressure: 5 words queued, m_ready=0 → exactly 2 rinc pulses, then cnt=2 and rinc=0. Raise m_ready → words 1..5 arrive in order with no gaps.
- Empty boundary: rempty=1 throughout → rinc never asserted and m_valid stays 0. If rempty falls for 1 cycle → exactly one word is delivered.
- Level wrap (ASIZE=3): rq2_wptr=gray(2)=4'b0011, rptr=gray(14)=4'b1001 → rlevel=4. rq2_wptr=gray(8)=4'b1100, rptr=gray(0)=4'b0000 → rlevel=8.
- Mid-stream reset: in FULL with m_ready=0, pulse rrst_n low for 1 cycle → m_valid=0 next cycle. The old words never appear after reset.
